// File: rtl/led_panel_scanner.sv
// rtl/led_panel_scanner.sv - HUB75 binary-coded-modulation scanner fed from a 24-bit frame buffer
//
// Reads two pixels per column (upper and lower half-panel), shifts one bit plane
// out on r1/g1/b1 and r2/g2/b2, then blanks, latches and displays the plane for
// BASE_CYC<<plane cycles. Rows and planes are walked in the order row-major,
// plane-minor.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   enable            start a frame (sampled only while idle)
//   brightness[7:0]   global dimming, present only with `define BRIGHTNESS_EN
//   ram_addr, ram_re  frame-buffer read port (data returns one cycle later)
//   ram_data[23:0]    {R,G,B} read data
//   r1,g1,b1,r2,g2,b2 panel colour bits
//   row_addr          panel row select
//   sclk, lat, oe_n   panel shift clock, latch, active-low output enable
//   busy, frame_done  frame in progress, end-of-frame pulse
//
// Optional feature macro: BRIGHTNESS_EN
module led_panel_scanner #(
    parameter int WIDTH    = 48,
    parameter int HEIGHT   = 48,
    parameter int ADDR_W   = 12,
    parameter int BPC      = 4,
    parameter int BASE_CYC = 8,
    parameter int ROW_W    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
`ifdef BRIGHTNESS_EN
    input  logic [7:0]        brightness,
`endif
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    input  logic [23:0]       ram_data,
    output logic              r1,
    output logic              g1,
    output logic              b1,
    output logic              r2,
    output logic              g2,
    output logic              b2,
    output logic [ROW_W-1:0]  row_addr,
    output logic              sclk,
    output logic              lat,
    output logic              oe_n,
    output logic              busy,
    output logic              frame_done
);
    localparam int HALF  = HEIGHT / 2;
    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PL_W  = (BPC > 1) ? $clog2(BPC) : 1;
    // One extra bit so the longest window length itself is representable.
    localparam int CNT_W = $clog2(BASE_CYC << (BPC - 1)) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_BLANK,
        S_LATCH,
        S_SHOW
    } state_t;

    state_t           state, state_nx;
    logic [ROW_W-1:0] row, row_nx;
    logic [PL_W-1:0]  plane, plane_nx;
    logic [COL_W-1:0] col, col_nx;
    logic [1:0]       phase, phase_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             frame_done_nx;

    logic [2:0]        bit_sel;
    logic [2:0]        data_bits;
    logic [2:0]        upper_q, rgb1_q, rgb2_q;
    logic [ADDR_W-1:0] upper_addr, lower_addr;
    logic [CNT_W-1:0]  win_len, lit_len;
    logic              last_col, last_plane, last_row, show_end;

    // Selects bit b of each colour byte of a pixel.
    function automatic logic [2:0] plane_bits(input logic [23:0] px, input logic [2:0] b);
        logic [7:0] rr, gg, bb;
        rr = px[23:16];
        gg = px[15:8];
        bb = px[7:0];
        return {rr[b], gg[b], bb[b]};
    endfunction

    assign bit_sel    = 3'(8 - BPC) + 3'(plane);
    assign data_bits  = plane_bits(ram_data, bit_sel);
    assign upper_addr = ADDR_W'(row) * ADDR_W'(WIDTH) + ADDR_W'(col);
    assign lower_addr = (ADDR_W'(row) + ADDR_W'(HALF)) * ADDR_W'(WIDTH) + ADDR_W'(col);
    assign win_len    = CNT_W'(BASE_CYC) << plane;
    assign last_col   = (col == COL_W'(WIDTH - 1));
    assign last_plane = (plane == PL_W'(BPC - 1));
    assign last_row   = (row == ROW_W'(HALF - 1));
    assign show_end   = (cnt == win_len - CNT_W'(1));

`ifdef BRIGHTNESS_EN
    logic [7:0]  bright_q;
    logic [15:0] lit_prod;

    // Lit portion of the window; the remainder of the window stays dark.
    assign lit_prod = 16'(bright_q) * 16'(win_len);
    assign lit_len  = CNT_W'(lit_prod >> 8);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bright_q <= '0;
        end else if (state == S_LATCH) begin
            bright_q <= brightness;
        end
    end
`else
    assign lit_len = win_len;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            row        <= '0;
            plane      <= '0;
            col        <= '0;
            phase      <= '0;
            cnt        <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            row        <= row_nx;
            plane      <= plane_nx;
            col        <= col_nx;
            phase      <= phase_nx;
            cnt        <= cnt_nx;
            frame_done <= frame_done_nx;
        end
    end

    // Pixel capture and held panel outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upper_q  <= '0;
            rgb1_q   <= '0;
            rgb2_q   <= '0;
            row_addr <= '0;
        end else begin
            if (state == S_SHIFT && phase == 2'd1) begin
                upper_q <= data_bits;
            end
            if (state == S_SHIFT && phase == 2'd2) begin
                rgb1_q <= upper_q;
                rgb2_q <= data_bits;
            end
            if (state == S_BLANK) begin
                row_addr <= row;
            end
        end
    end

    always_comb begin
        state_nx      = state;
        row_nx        = row;
        plane_nx      = plane;
        col_nx        = col;
        phase_nx      = phase;
        cnt_nx        = cnt;
        frame_done_nx = 1'b0;
        ram_addr      = '0;
        ram_re        = 1'b0;
        sclk          = 1'b0;
        lat           = 1'b0;
        oe_n          = 1'b1;
        busy          = (state != S_IDLE);
        {r1, g1, b1}  = rgb1_q;
        {r2, g2, b2}  = rgb2_q;

        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_nx = S_SHIFT;
                    row_nx   = '0;
                    plane_nx = '0;
                    col_nx   = '0;
                    phase_nx = '0;
                end
            end
            S_SHIFT: begin
                phase_nx = phase + 2'd1;
                case (phase)
                    2'd0: begin
                        ram_addr = upper_addr;
                        ram_re   = 1'b1;
                    end
                    2'd1: begin
                        ram_addr = lower_addr;
                        ram_re   = 1'b1;
                    end
                    2'd2: begin
                        // Lower pixel arrives this cycle; present the new bits
                        // a full cycle ahead of the sclk rising edge.
                        {r1, g1, b1} = upper_q;
                        {r2, g2, b2} = data_bits;
                    end
                    default: begin
                        sclk = 1'b1;
                        if (last_col) begin
                            state_nx = S_BLANK;
                            col_nx   = '0;
                        end else begin
                            col_nx = col + COL_W'(1);
                        end
                    end
                endcase
            end
            S_BLANK: begin
                state_nx = S_LATCH;
            end
            S_LATCH: begin
                lat      = 1'b1;
                cnt_nx   = '0;
                state_nx = S_SHOW;
            end
            S_SHOW: begin
                oe_n   = (cnt >= lit_len);
                cnt_nx = cnt + CNT_W'(1);
                if (show_end) begin
                    if (!last_plane) begin
                        plane_nx = plane + PL_W'(1);
                        state_nx = S_SHIFT;
                    end else if (!last_row) begin
                        plane_nx = '0;
                        row_nx   = row + ROW_W'(1);
                        state_nx = S_SHIFT;
                    end else begin
                        frame_done_nx = 1'b1;
                        state_nx      = S_IDLE;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_led_panel_scanner.sv
// tb/tb_led_panel_scanner.sv - self-checking bench for led_panel_scanner
module tb_led_panel_scanner;
    localparam int W    = 48;
    localparam int H    = 48;
    localparam int HALF = H / 2;
    localparam int BPC  = 4;
    localparam int BASE = 8;
    localparam int AW   = 12;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          enable = 1'b0;
`ifdef BRIGHTNESS_EN
    logic [7:0]    brightness = 8'd255;
`endif
    logic [AW-1:0] ram_addr;
    logic          ram_re;
    logic [23:0]   ram_data = '0;
    logic          r1, g1, b1, r2, g2, b2;
    logic [4:0]    row_addr;
    logic          sclk, lat, oe_n, busy, frame_done;

    always #5 clk = ~clk;

    led_panel_scanner dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
`ifdef BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .ram_addr   (ram_addr),
        .ram_re     (ram_re),
        .ram_data   (ram_data),
        .r1         (r1),
        .g1         (g1),
        .b1         (b1),
        .r2         (r2),
        .g2         (g2),
        .b2         (b2),
        .row_addr   (row_addr),
        .sclk       (sclk),
        .lat        (lat),
        .oe_n       (oe_n),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Frame buffer with one-cycle registered read.
    logic [23:0] fb [W*H];
    always @(posedge clk) if (ram_re) ram_data <= fb[ram_addr];

    // Passive recorder of everything the panel and the RAM see.
    logic [5:0] rgb_log[$];
    int         addr_log[$];
    int         lat_log[$];
    int         oe_log[$];
    int         oe_run   = 0;
    int         busy_cyc = 0;
    int         done_cnt = 0;
    logic       sclk_d   = 1'b0;

    always @(negedge clk) begin
        if (sclk && !sclk_d) rgb_log.push_back({r1, g1, b1, r2, g2, b2});
        if (ram_re) addr_log.push_back(int'(ram_addr));
        if (lat) lat_log.push_back(int'(row_addr));
        if (!oe_n) oe_run <= oe_run + 1;
        else if (oe_run != 0) begin
            oe_log.push_back(oe_run);
            oe_run <= 0;
        end
        if (busy) busy_cyc <= busy_cyc + 1;
        if (frame_done) done_cnt <= done_cnt + 1;
        sclk_d <= sclk;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] exp_bits(input int r, input int p, input int c);
        logic [23:0] u, l;
        int b;
        u = fb[r*W + c];
        l = fb[(r + HALF)*W + c];
        b = 8 - BPC + p;
        return {u[16+b], u[8+b], u[b], l[16+b], l[8+b], l[b]};
    endfunction

    int s_r, s_a, s_l, s_o, s_b, s_d;
    task automatic snap();
        s_r = rgb_log.size();
        s_a = addr_log.size();
        s_l = lat_log.size();
        s_o = oe_log.size();
        s_b = busy_cyc;
        s_d = done_cnt;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 25000);
        chk({tag, " frame_done_seen"}, frame_done, 1);
        @(posedge clk);
        #1;
    endtask

    // Compares the recorded frame since the last snapshot with the scan rules.
    // bri > 255 means the full window is lit.
    task automatic check_frame(input string tag, input int bri);
        int k, mis, len, lit, exp_busy, sum_show;
        int exp_oe[$];
        mis = 0;
        k = s_r;
        for (int r = 0; r < HALF; r++)
            for (int p = 0; p < BPC; p++)
                for (int c = 0; c < W; c++) begin
                    if (k >= rgb_log.size() || rgb_log[k] !== exp_bits(r, p, c)) mis++;
                    k++;
                end
        chk({tag, " rgb_bits_mismatches"}, mis, 0);
        chk({tag, " sclk_edges"}, rgb_log.size() - s_r, HALF*BPC*W);

        mis = 0;
        k = s_a;
        for (int r = 0; r < HALF; r++)
            for (int p = 0; p < BPC; p++)
                for (int c = 0; c < W; c++) begin
                    if (k + 1 >= addr_log.size() || addr_log[k] != r*W + c ||
                        addr_log[k+1] != (r + HALF)*W + c) mis++;
                    k += 2;
                end
        chk({tag, " ram_addr_mismatches"}, mis, 0);
        chk({tag, " ram_reads"}, addr_log.size() - s_a, 2*HALF*BPC*W);
        k = s_a + ((5*BPC + 0)*W + 2)*2;
        chk({tag, " addr_row5_col2_upper"}, (k + 1 < addr_log.size()) ? addr_log[k] : -1, 242);
        chk({tag, " addr_row5_col2_lower"}, (k + 1 < addr_log.size()) ? addr_log[k+1] : -1, 1394);

        mis = 0;
        k = s_l;
        for (int r = 0; r < HALF; r++)
            for (int p = 0; p < BPC; p++) begin
                if (k >= lat_log.size() || lat_log[k] != r) mis++;
                k++;
            end
        chk({tag, " lat_row_mismatches"}, mis, 0);
        chk({tag, " lat_pulses"}, lat_log.size() - s_l, HALF*BPC);

        sum_show = 0;
        for (int p = 0; p < BPC; p++) sum_show += BASE << p;
        for (int r = 0; r < HALF; r++)
            for (int p = 0; p < BPC; p++) begin
                len = BASE << p;
                lit = (bri > 255) ? len : ((bri * len) >> 8);
                if (lit > 0) exp_oe.push_back(lit);
            end
        mis = 0;
        for (int i = 0; i < exp_oe.size(); i++)
            if (s_o + i >= oe_log.size() || oe_log[s_o + i] != exp_oe[i]) mis++;
        chk({tag, " oe_run_mismatches"}, mis, 0);
        chk({tag, " oe_runs"}, oe_log.size() - s_o, exp_oe.size());
        if (exp_oe.size() >= BPC) begin
            chk({tag, " oe_plane0_run"}, (s_o < oe_log.size()) ? oe_log[s_o] : -1, exp_oe[0]);
            chk({tag, " oe_plane3_run"}, (s_o + 3 < oe_log.size()) ? oe_log[s_o+3] : -1, exp_oe[3]);
        end

        exp_busy = HALF * (BPC*(4*W + 2) + sum_show);
        chk({tag, " busy_cycles"}, busy_cyc - s_b, exp_busy);
        chk({tag, " frame_done_pulses"}, done_cnt - s_d, 1);
    endtask

    int bri_a, bri_b, ok_cnt, n, ones, a0, l0;
    bit found;

    initial begin
`ifdef BRIGHTNESS_EN
        bri_a = 128;
        bri_b = 0;
`else
        bri_a = 256;
        bri_b = 256;
`endif
        // Reset and idle quiet period.
        repeat (3) @(negedge clk);
        chk("reset_values",
            {ram_re, oe_n, busy, sclk, lat, frame_done, r1, g1, b1, r2, g2, b2, row_addr, ram_addr},
            {6'b010000, 6'b000000, 5'd0, 12'd0});
        rst_n = 1'b1;
        ok_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ram_re === 1'b0 && oe_n === 1'b1 && busy === 1'b0 && sclk === 1'b0 &&
                lat === 1'b0 && frame_done === 1'b0 && {r1, g1, b1, r2, g2, b2} === 6'b0 &&
                row_addr === 5'd0 && ram_addr === '0) ok_cnt++;
        end
        chk("idle_quiet_cycles", ok_cnt, 100);

        // Frame A: random image, enable dropped mid-frame.
        for (int i = 0; i < W*H; i++) fb[i] = 24'($urandom);
`ifdef BRIGHTNESS_EN
        brightness = 8'(bri_a);
`endif
        snap();
        enable = 1'b1;
        repeat (50) @(negedge clk);
        chk("busy_after_start", busy, 1);
        enable = 1'b0;
        wait_done("frameA");
        check_frame("frameA", bri_a);
        chk("frameA no_restart_when_disabled", busy, 0);

        // Frame B: two lit bits only, enable held for a back-to-back frame.
        for (int i = 0; i < W*H; i++) fb[i] = 24'h0;
        fb[0]    = 24'h800000;
        fb[1152] = 24'h000080;
`ifdef BRIGHTNESS_EN
        brightness = 8'(bri_b);
`endif
        repeat (5) @(negedge clk);
        snap();
        enable = 1'b1;
        wait_done("frameB");
        chk("frameB back_to_back_busy", busy, 1);
        check_frame("frameB", bri_b);
        chk("frameB row0_plane3_col0", (s_r + 3*W < rgb_log.size()) ? rgb_log[s_r + 3*W] : 6'h3f,
            6'b100001);
        ones = 0;
        for (int i = s_r; i < rgb_log.size(); i++) ones += $countones(rgb_log[i]);
        chk("frameB total_lit_bits", ones, 2);
`ifdef BRIGHTNESS_EN
        brightness = 8'd255;
`endif

        // Frame C: reset during the display of row 10.
        found = 1'b0;
        n = 0;
        while (!found && n < 15000) begin
            @(negedge clk);
            n++;
            if (row_addr == 5'd10 && oe_n == 1'b0) found = 1'b1;
        end
        chk("reach_row10_show", found, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset oe_n", oe_n, 1);
        chk("async_reset row_addr", row_addr, 0);
        chk("async_reset busy", busy, 0);
        chk("async_reset lat_sclk_re", {lat, sclk, ram_re}, 3'b000);
        repeat (2) @(negedge clk);
        a0 = addr_log.size();
        l0 = lat_log.size();
        rst_n = 1'b1;
        n = 0;
        while (addr_log.size() < a0 + 4 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("restart addr0", (addr_log.size() >= a0 + 4) ? addr_log[a0] : -1, 0);
        chk("restart addr1", (addr_log.size() >= a0 + 4) ? addr_log[a0+1] : -1, 1152);
        chk("restart addr2", (addr_log.size() >= a0 + 4) ? addr_log[a0+2] : -1, 1);
        chk("restart addr3", (addr_log.size() >= a0 + 4) ? addr_log[a0+3] : -1, 1153);
        n = 0;
        while (lat_log.size() <= l0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("restart first_lat_row", (lat_log.size() > l0) ? lat_log[l0] : -1, 0);
        enable = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/led_panel_scanner.md
Name: led_panel_scanner

Overview:
- Read-side consumer of the 24-bit frame buffer; drives the RAM's read port (read enable, address, 1-cycle registered data).
- Scans the stored image out to a HUB75-style LED matrix: two half-panel rows shifted in parallel, binary-coded modulation (BCM) for brightness, row select, latch and output-enable.
- Sits between the frame-buffer read port and the panel connector pins.

Parameters:
WIDTH, 48, panel columns
HEIGHT, 48, panel rows (even); rows 0..HEIGHT/2-1 on r1/g1/b1, rest on r2/g2/b2
ADDR_W, 12, frame-buffer address width (WIDTH*HEIGHT <= 2**ADDR_W)
BPC, 4, bit planes per colour channel; uses channel MSBs [7:8-BPC]
BASE_CYC, 8, display cycles for plane 0; plane p shows BASE_CYC<<p cycles
ROW_W, 5, row_addr width (>= clog2(HEIGHT/2))

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  scanning allowed; sampled only at frame start
ram_addr  out  ADDR_W  frame-buffer read address
ram_re  out  1  frame-buffer read enable
ram_data  in  24  read data {R[23:16],G[15:8],B[7:0]}, valid 1 cycle after ram_re
r1,g1,b1  out  1 each  upper-half pixel bits
r2,g2,b2  out  1 each  lower-half pixel bits
row_addr  out  ROW_W  panel row select (A..E)
sclk  out  1  panel shift clock, data sampled on rising edge
lat  out  1  panel latch, active high
oe_n  out  1  panel output enable, active low
busy  out  1  high while a frame is in progress
frame_done  out  1  one-cycle pulse after the last plane of the last row

Behaviour:
- Reset (async assert, sync release): ram_addr=0, ram_re=0, all rgb=0, row_addr=0, sclk=0, lat=0, oe_n=1, busy=0, frame_done=0; state IDLE, row=0, plane=0, col=0.
- Scan order: for row 0..HEIGHT/2-1, for plane 0..BPC-1: SHIFT, BLANK, LATCH, SHOW.
- IDLE: oe_n=1, busy=0. If enable=1, go to SHIFT with row=0, plane=0, col=0, and busy=1 from the next cycle.
- SHIFT: 4 phases per column.
  - P0: ram_addr=row*WIDTH+col, ram_re=1.
  - P1: ram_addr=(row+HEIGHT/2)*WIDTH+col, ram_re=1; capture upper pixel.
  - P2: ram_re=0; capture lower pixel; drive r1=R[8-BPC+plane], g1, b1 from upper and r2, g2, b2 from lower; sclk=0.
  - P3: sclk=1.
  - After P3 of col WIDTH-1, go to BLANK with sclk=0; otherwise col+1, back to P0.
  - Total 4*WIDTH cycles with exactly WIDTH sclk rising edges.
  - oe_n=1 throughout SHIFT (no overlap of shifting and display).
- BLANK (1 cycle): oe_n=1; row_addr<=row.
- LATCH (1 cycle): lat=1; lat=0 in all other states.
- SHOW: oe_n=0 for exactly BASE_CYC<<plane cycles, counter width sufficient for BASE_CYC<<(BPC-1). Then oe_n=1 and:
  - plane<BPC-1: plane+1, SHIFT.
  - else if row<HEIGHT/2-1: plane=0, row+1, SHIFT.
  - else: frame_done=1 for one cycle, then IDLE. Back-to-back frames follow if enable is still 1; one IDLE cycle between frames.
- enable deasserted mid-frame: the current frame completes.
- rgb hold their last value outside P2 updates. row_addr changes only in BLANK.
- Address arithmetic is ADDR_W bits; no wrap occurs for legal parameters.
- Reset mid-frame: immediate return to reset values. oe_n goes to 1 asynchronously, so the panel is never left lit.

Optional Feature:
BRIGHTNESS_EN
- Defined: adds input brightness[7:0]. In SHOW the window length is still BASE_CYC<<plane, but oe_n=0 only for the first (brightness*(BASE_CYC<<plane))>>8 cycles, 16-bit intermediate product.
  - brightness=0: oe_n stays 1 for the whole window.
  - brightness=255 at plane 3: 63 of 64 cycles lit.
  - brightness is sampled at SHOW entry.
- Not defined: no port; oe_n=0 for the full window.

Test Plan:
- Reset with enable=0 -> all outputs at reset values, busy=0, no ram_re for 100 cycles.
- Frame buffer all 0xFFFFFF, enable=1 -> first plane: 48 sclk rising edges in 192 cycles, every rgb=1 at each edge; one lat pulse; oe_n low exactly 8 cycles. Plane 3 shows 64 cycles.
- Pixel at addr 0 = 0x800000, pixel at addr 1152 = 0x000080, others 0 -> row 0, plane 3, first column: r1=1, b2=1. All other columns and planes have rgb=0.
- Full frame -> ram_addr sequence for row 5 col 2 gives 242 then 1394. row_addr steps 0..23. frame_done pulses once after 24*4 planes. Total cycle count matches the formula.
- Assert rst_n low during SHOW of row 10 -> oe_n=1 and row_addr=0 in the same cycle. After release with enable=1, the scan restarts at row 0 plane 0.
- BRIGHTNESS_EN defined, brightness=128 -> plane 0: 4 of 8 cycles lit; plane 3: 32 of 64 lit. brightness=0 -> oe_n never low.
